// File: rtl/ntt_address_unit_pkg.sv
// Shared constants for the Dilithium polynomial address sequencer.
package dilithium_pkg;
  localparam int RAM_ADDR_W = 6;
  localparam int TW_ADDR_W  = 8;
  localparam int WORDS      = 64;
  localparam int NTT_PASSES = 4;

  localparam logic [2:0] FWD_NTT = 3'd0;
  localparam logic [2:0] INV_NTT = 3'd1;
  localparam logic [2:0] MULT    = 3'd2;
  localparam logic [2:0] ADD     = 3'd3;
  localparam logic [2:0] SUB     = 3'd4;

  function automatic logic is_ntt(input logic [2:0] mode);
    return (mode == FWD_NTT) || (mode == INV_NTT);
  endfunction
endpackage

// File: rtl/ntt_address_unit_if.sv
// Control/address bundle between the polynomial op controller and the address unit.
interface ntt_address_unit_if;
  import dilithium_pkg::*;
  logic [2:0]            mode;
  logic [1:0]            encode_mode;
  logic                  en;
  logic [RAM_ADDR_W-1:0] ram_nat;
  logic [RAM_ADDR_W-1:0] ram_addr;
  logic [TW_ADDR_W-1:0]  twiddle_addr0;
  logic [TW_ADDR_W-1:0]  twiddle_addr1;
  logic [TW_ADDR_W-1:0]  twiddle_addr2;
  logic [TW_ADDR_W-1:0]  twiddle_addr3;
  logic                  ntt_round_done;
  logic                  done;

  modport master (
    output mode, encode_mode, en,
    input  ram_nat, ram_addr, twiddle_addr0, twiddle_addr1, twiddle_addr2,
           twiddle_addr3, ntt_round_done, done
  );
  modport slave (
    input  mode, encode_mode, en,
    output ram_nat, ram_addr, twiddle_addr0, twiddle_addr1, twiddle_addr2,
           twiddle_addr3, ntt_round_done, done
  );
endinterface

// File: rtl/ntt_address_unit_twiddle_gen.sv
// Zeta-ROM index generator for a 2-layer butterfly step, purely combinational.
module ntt_twiddle_gen
  import dilithium_pkg::*;
(
  input  logic [2:0]            mode,
  input  logic [1:0]            p,
  input  logic [RAM_ADDR_W-1:0] j,
  output logic [TW_ADDR_W-1:0]  tw0,
  output logic [TW_ADDR_W-1:0]  tw1,
  output logic [TW_ADDR_W-1:0]  tw2,
  output logic [TW_ADDR_W-1:0]  tw3
);
  logic [1:0]           q;
  logic [TW_ADDR_W-1:0] b, g, lo, hi;

  always_comb begin
    // inverse walks the layer pairs in reverse order
    q = (mode == INV_NTT) ? (2'd3 - p) : p;
    b = '0;
    g = '0;
    case (q)
      2'd0: begin b = 8'd1;  g = '0;                 end
      2'd1: begin b = 8'd4;  g = {6'b0, j[5:4]};     end
      2'd2: begin b = 8'd16; g = {4'b0, j[5:2]};     end
      2'd3: begin b = 8'd64; g = {2'b0, j};          end
      default: ;
    endcase
    lo = b + g;
    hi = {lo[6:0], 1'b0};
    tw0 = '0;
    tw1 = '0;
    tw2 = '0;
    tw3 = '0;
    if (mode == FWD_NTT) begin
      tw0 = lo;
      tw1 = lo;
      tw2 = hi;
      tw3 = hi | 8'd1;
    end else if (mode == INV_NTT) begin
      tw0 = hi;
      tw1 = hi | 8'd1;
      tw2 = lo;
      tw3 = lo;
    end
  end
endmodule

// File: rtl/ntt_address_unit.sv
// Word/pass counter with pass and completion pulses; twiddle indices derived from (mode, p, j).
module ntt_address_unit
  import dilithium_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  ntt_address_unit_if.slave bus
);
  logic [RAM_ADDR_W-1:0] j;
  logic [1:0]            p;
  logic                  round_done_q, done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      j            <= '0;
      p            <= '0;
      round_done_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      round_done_q <= 1'b0;
      done_q       <= 1'b0;
      if (bus.en) begin
        j <= j + 6'd1;
        if (j == 6'(WORDS - 1)) begin
          if (is_ntt(bus.mode) && p != 2'(NTT_PASSES - 1)) begin
            p            <= p + 2'd1;
            round_done_q <= 1'b1;
          end else begin
            p      <= '0;
            done_q <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.ram_nat        = j;
  assign bus.ram_addr       = j;
  assign bus.ntt_round_done = round_done_q;
  assign bus.done           = done_q;

  ntt_twiddle_gen u_tw (
    .mode (bus.mode),
    .p    (p),
    .j    (j),
    .tw0  (bus.twiddle_addr0),
    .tw1  (bus.twiddle_addr1),
    .tw2  (bus.twiddle_addr2),
    .tw3  (bus.twiddle_addr3)
  );
endmodule

// File: tb/tb_ntt_address_unit.sv
// Scoreboard bench: the driver pushes step-based expectations, a monitor pops and compares each cycle.
module tb_ntt_address_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  ntt_address_unit_if bus();

  ntt_address_unit dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    bit       chk;
    int       addr;
    int       tw[4];
    bit       rd;
    bit       dn;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // reference model: position inside the whole operation, in enabled steps
  int   step    = 0;
  int   cur_mode = 0;
  bit   pend_rd = 0;
  bit   pend_dn = 0;

  function automatic int total_steps(input int m);
    return (m == 0 || m == 1) ? 256 : 64;
  endfunction

  function automatic exp_t model(input int m, input int s);
    exp_t e;
    int pass, jj, q, bb, g;
    e.chk  = 1;
    pass   = s / 64;
    jj     = s % 64;
    e.addr = jj;
    e.rd   = pend_rd;
    e.dn   = pend_dn;
    for (int k = 0; k < 4; k++) e.tw[k] = 0;
    if (m == 0 || m == 1) begin
      q  = (m == 0) ? pass : 3 - pass;
      bb = 4 ** q;
      g  = jj / (64 / bb);
      if (m == 0) begin
        e.tw[0] = bb + g;     e.tw[1] = bb + g;
        e.tw[2] = 2*bb + 2*g; e.tw[3] = 2*bb + 2*g + 1;
      end else begin
        e.tw[0] = 2*bb + 2*g; e.tw[1] = 2*bb + 2*g + 1;
        e.tw[2] = bb + g;     e.tw[3] = bb + g;
      end
    end
    return e;
  endfunction

  task automatic drive(input bit e, input bit r);
    exp_t x;
    @(posedge clk);
    #1;
    rst              = r;
    bus.en           = e;
    bus.mode         = 3'(cur_mode);
    bus.encode_mode  = 2'($urandom_range(0, 3));
    x = model(cur_mode, step);
    if (r) begin
      x.chk   = 0;
      step    = 0;
      pend_rd = 0;
      pend_dn = 0;
    end else begin
      pend_rd = 0;
      pend_dn = 0;
      if (e) begin
        step++;
        if (step == total_steps(cur_mode)) begin
          pend_dn = 1;
          step    = 0;
        end else if (step % 64 == 0) begin
          pend_rd = 1;
        end
      end
    end
    exp_q.push_back(x);
  endtask

  task automatic check(input string nm, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      if (x.chk) begin
        if ($isunknown({bus.ram_addr, bus.twiddle_addr0, bus.done, bus.ntt_round_done})) begin
          n_checks++;
          n_fail++;
          $display("FAIL unknown_outputs: got X expected known (t=%0t)", $time);
        end
        check("ram_addr", int'(bus.ram_addr), x.addr);
        check("ram_nat", int'(bus.ram_nat), x.addr);
        check("tw0", int'(bus.twiddle_addr0), x.tw[0]);
        check("tw1", int'(bus.twiddle_addr1), x.tw[1]);
        check("tw2", int'(bus.twiddle_addr2), x.tw[2]);
        check("tw3", int'(bus.twiddle_addr3), x.tw[3]);
        check("ntt_round_done", int'(bus.ntt_round_done), int'(x.rd));
        check("done", int'(bus.done), int'(x.dn));
      end
    end
  end

  task automatic run(input int m, input int n_en);
    cur_mode = m;
    for (int i = 0; i < n_en; i++) drive(1, 0);
    drive(0, 0);
  endtask

  int done_seen;

  initial begin
    bus.en          = 1'b0;
    bus.mode        = 3'd0;
    bus.encode_mode = 2'd0;
    drive(0, 1);
    drive(0, 1);
    drive(0, 0);               // reset state
    run(0, 256);               // forward NTT
    run(1, 256);               // inverse NTT
    run(2, 64);                // pointwise mult
    cur_mode = 0;              // en toggling 1,0,...
    for (int i = 0; i < 512; i++) drive(i % 2 == 0, 0);
    drive(0, 0);
    cur_mode = 0;              // abort at step 100
    for (int i = 0; i < 100; i++) drive(1, 0);
    drive(0, 1);
    drive(0, 0);
    run(0, 256);
    cur_mode = 3;              // add then sub, no reset between
    for (int i = 0; i < 64; i++) drive(1, 0);
    cur_mode = 4;
    for (int i = 0; i < 64; i++) drive(1, 0);
    drive(0, 0);
    // random modes (incl. 5..7) with random enable gaps
    for (int r = 0; r < 6; r++) begin
      cur_mode = $urandom_range(0, 7);
      done_seen = 0;
      for (int c = 0; c < 1500 && done_seen == 0; c++) begin
        drive(($urandom_range(0, 3) != 0), 0);
        if (pend_dn) done_seen = 1;
      end
      drive(0, 0);
    end
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ntt_address_unit.md
Name: ntt_address_unit

Overview:
- Address and twiddle-index sequencer for the Dilithium polynomial operation module.
- Polynomial storage: 64 words × 4 packed 24-bit coefficients (256 coefficients).
- Generates the RAM word address, a natural-order word counter, and four 8-bit zeta-ROM indices per step for a 2-layer (2×2) butterfly unit.
- Signals pass boundaries and completion for forward NTT, inverse NTT and pointwise mult/add/sub.

Parameters:
- None. Widths are fixed: 6-bit RAM address, 8-bit twiddle index, 2-bit pass counter.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset. The parent drives it as rst|start.
- mode  in  3  0=FWD_NTT, 1=INV_NTT, 2=MULT, 3=ADD, 4=SUB; 5–7 behave as MULT.
- encode_mode  in  2  reserved; kept for interface compatibility; no effect on any output.
- en  in  1  advance one step this cycle.
- ram_nat  out  6  natural word counter j.
- ram_addr  out  6  RAM word address for the current step.
- twiddle_addr0  out  8  stage-1 zeta index, butterfly A.
- twiddle_addr1  out  8  stage-1 zeta index, butterfly B.
- twiddle_addr2  out  8  stage-2 zeta index, butterfly A.
- twiddle_addr3  out  8  stage-2 zeta index, butterfly B.
- ntt_round_done  out  1  one-cycle pulse: an NTT pass (not the last) finished.
- done  out  1  one-cycle pulse: the whole sequence finished.

Behaviour:
- State:
  - j: 6-bit word counter.
  - p: 2-bit pass counter.
  - ntt_round_done and done: registered pulses.
- Reset (rst=1 at an edge): j=0, p=0, ntt_round_done=0, done=0. Reset wins over en on the same edge.
- Outputs are combinational from (j, p, mode), so the address is valid in the same cycle en is sampled.
  - ram_addr = j and ram_nat = j in all modes.
- en=0: j, p and all address outputs hold; pulses go to 0.
- en=1, NTT modes (FWD, INV):
  - j increments.
  - At j=63 with p<3: j→0, p→p+1, ntt_round_done=1 next cycle.
  - At j=63 with p=3: j→0, p→0, done=1 next cycle. ntt_round_done is not raised on the final pass.
- en=1, pointwise modes (MULT, ADD, SUB):
  - p stays 0; j increments.
  - At j=63: j→0, done=1 next cycle. ntt_round_done is never asserted.
- Total steps: 256 enabled cycles per NTT (4 passes × 64), 64 per pointwise operation.
- Parent stalls en during the ntt_round_done cycle. The unit does not depend on that, but an en in that cycle is honoured normally.
- Twiddle indices, FWD_NTT (Cooley-Tukey, Dilithium zeta order). Let q = pass index p, g = j >> (6−2q), B = 4^q:
  - addr0 = addr1 = B + g.
  - addr2 = 2B + 2g.
  - addr3 = 2B + 2g + 1.
  - Pass 0: 1,1,2,3 constant.
  - Pass 3: 64+j, 64+j, 128+2j, 129+2j.
- Twiddle indices, INV_NTT (Gentleman-Sande, layers reversed). Let q = 3−p, with g and B as above:
  - addr0 = 2B + 2g, addr1 = 2B + 2g + 1 (stage-1 zetas).
  - addr2 = addr3 = B + g (stage-2 zeta).
  - Zeta negation is done by the butterfly, not here.
- Twiddle indices, pointwise modes: all four = 0.
- After done, the unit is idle at j=0, p=0. A further en restarts the sequence from step 0.
- mode must be stable from reset until done. A mode change mid-run applies the new formulas to the current (j, p) with no other side effect.
- Reset mid-operation aborts immediately; no done pulse is produced.

Decomposition:
- Shared package (dilithium_pkg):
  - mode constants FWD_NTT/INV_NTT/MULT/ADD/SUB;
  - RAM_ADDR_W=6, TW_ADDR_W=8, WORDS=64, NTT_PASSES=4.
- One natural combinational sub-module, ntt_twiddle_gen: (mode, p, j) → four indices. The counter/pulse logic stays in ntt_address_unit.

Test Plan:
- Reset, then mode=FWD, en=1 for 256 cycles:
  - step 0 → ram_addr 0, tw 1/1/2/3;
  - step 192 (p=3, j=0) → tw 64/64/128/129;
  - step 255 → tw 127/127/254/255;
  - ntt_round_done pulses after steps 63, 127, 191;
  - done pulses once, cycle after step 255.
- mode=INV, 256 enables:
  - step 0 (q=3, j=0) → tw 128/129/64/64;
  - step 255 (q=0) → tw 2/3/1/1;
  - pulses at the same step counts as FWD.
- mode=MULT, 64 enables:
  - ram_addr = ram_nat = 0..63;
  - tw all 0;
  - done one cycle after step 63;
  - ntt_round_done never high.
- FWD with en toggled 1,0,1 every cycle: outputs hold during en=0; 512 total cycles; same done timing relative to the 256th enable.
- Assert rst at FWD step 100:
  - next cycle ram_addr 0, tw 1/1/2/3, no done;
  - a full 256-enable rerun completes normally.
- ADD then SUB back-to-back: done after 64 enables each; second run starts at ram_addr 0 without an intervening reset.
